user_io_wb_ctrl: RTL and testbench

//  Wishbone slave between the management SoC bus and the user-area GPIO pads, next to ChipTop in the user wrapper.
//  - Samples pad inputs through a synchronizer.
//  - Detects rising/falling edges and raises a level interrupt on irq[0].
//  - Provides per-pin output override values and enables; the wrapper muxes these over ChipTop's pad outputs.
//  - Drives wbs_ack_o/wbs_dat_o, which are otherwise unused.

---
 rtl/user_io_wb_ctrl_pkg.sv | 23 ++
 rtl/user_io_wb_ctrl_if.sv | 15 +
 rtl/user_io_wb_ctrl_io_sync_edge.sv | 27 ++
 rtl/user_io_wb_ctrl.sv | 111 +++++++++++
 tb/tb_user_io_wb_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/user_io_wb_ctrl_pkg.sv
// user_io_pkg: register map, ID constant and Wishbone decode/byte-merge helpers for user_io_wb_ctrl.
package user_io_pkg;
  typedef enum logic {S_IDLE, S_ACK} wb_state_e;
  localparam logic [7:0] OFF_IN      = 8'h00;
  localparam logic [7:0] OFF_OVR_OUT = 8'h04;
  localparam logic [7:0] OFF_OVR_EN  = 8'h08;
  localparam logic [7:0] OFF_RISE_EN = 8'h0C;
  localparam logic [7:0] OFF_FALL_EN = 8'h10;
  localparam logic [7:0] OFF_STATUS  = 8'h14;
  localparam logic [7:0] OFF_ID      = 8'h18;
  localparam logic [7:0] OFF_CNT     = 8'h1C;
  localparam logic [7:0] OFF_TSTAMP  = 8'h20;
  localparam logic [31:0] IO_ID = 32'h494F_4331;
  function automatic logic wb_hit(input logic [31:0] adr, input logic [31:0] base);
    return adr[31:8] == base[31:8];
  endfunction
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction
  function automatic logic [31:0] sel_merge(input logic [31:0] old, input logic [31:0] wdat, input logic [3:0] sel);
    return (old & ~byte_mask(sel)) | (wdat & byte_mask(sel));
  endfunction
endpackage

// File: rtl/user_io_wb_ctrl_if.sv
// user_io_wb_ctrl_if: Wishbone slave-side signal bundle between the management SoC and user_io_wb_ctrl.
interface user_io_wb_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  modport master (output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                  input wbs_ack_o, wbs_dat_o);
  modport slave (input wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                 output wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/user_io_wb_ctrl_io_sync_edge.sv
// io_sync_edge: multi-flop pad synchronizer plus one-cycle rise/fall pulses from the last stage.
module io_sync_edge #(
  parameter int NIO         = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [NIO-1:0] d_i,
  output logic [NIO-1:0] q_o,
  output logic [NIO-1:0] rise_o,
  output logic [NIO-1:0] fall_o
);
  logic [SYNC_STAGES-1:0][NIO-1:0] sync_q;
  logic [NIO-1:0] prev_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end
  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;
endmodule

// File: rtl/user_io_wb_ctrl.sv
// user_io_wb_ctrl: Wishbone slave for user GPIO sampling, edge interrupts and pad output overrides.
// Optional USER_IO_TIMESTAMP_EN adds a free-running CNT and a TSTAMP captured on the first pending edge.
module user_io_wb_ctrl
  import user_io_pkg::*;
#(
  parameter int          NIO         = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  user_io_wb_ctrl_if.slave     wb,
  input  logic [NIO-1:0]       io_in,
  output logic [NIO-1:0]       ovr_out,
  output logic [NIO-1:0]       ovr_en,
  output logic                 irq_o
);
  wb_state_e state_q, state_d;
  logic [31:0] rdata_q, rdata_d, rd_val;
  logic [NIO-1:0] ovr_out_q, ovr_out_d, ovr_en_q, ovr_en_d;
  logic [NIO-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [NIO-1:0] status_q, status_d, clr;
  logic [NIO-1:0] pin_sync, rise, fall;
  logic [7:0] off;
  logic accept, wr;
  logic unused_adr;
  assign unused_adr = ^wb.wbs_adr_i[1:0];
  io_sync_edge #(.NIO(NIO), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i (wb_clk_i),
    .rst_i (wb_rst_i),
    .d_i   (io_in),
    .q_o   (pin_sync),
    .rise_o(rise),
    .fall_o(fall)
  );
  assign off    = {wb.wbs_adr_i[7:2], 2'b00};
  assign accept = wb.wbs_stb_i & wb.wbs_cyc_i & (state_q == S_IDLE) & wb_hit(wb.wbs_adr_i, BASE_ADDR);
  assign wr     = accept & wb.wbs_we_i;
`ifdef USER_IO_TIMESTAMP_EN
  logic [31:0] cnt_q, cnt_d, tstamp_q, tstamp_d;
  always_comb begin
    cnt_d    = cnt_q + 32'd1;
    tstamp_d = (status_q == '0 && status_d != '0) ? cnt_d : tstamp_q;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q    <= '0;
      tstamp_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      tstamp_q <= tstamp_d;
    end
  end
`endif
  always_comb begin
    rd_val = '0;
    case (off)
      OFF_IN:      rd_val = 32'(pin_sync);
      OFF_OVR_OUT: rd_val = 32'(ovr_out_q);
      OFF_OVR_EN:  rd_val = 32'(ovr_en_q);
      OFF_RISE_EN: rd_val = 32'(rise_en_q);
      OFF_FALL_EN: rd_val = 32'(fall_en_q);
      OFF_STATUS:  rd_val = 32'(status_q);
      OFF_ID:      rd_val = IO_ID;
`ifdef USER_IO_TIMESTAMP_EN
      OFF_CNT:     rd_val = cnt_q;
      OFF_TSTAMP:  rd_val = tstamp_q;
`endif
      default:     rd_val = '0;
    endcase
  end
  always_comb begin
    ovr_out_d = (wr && off == OFF_OVR_OUT) ? NIO'(sel_merge(32'(ovr_out_q), wb.wbs_dat_i, wb.wbs_sel_i)) : ovr_out_q;
    ovr_en_d  = (wr && off == OFF_OVR_EN)  ? NIO'(sel_merge(32'(ovr_en_q), wb.wbs_dat_i, wb.wbs_sel_i))  : ovr_en_q;
    rise_en_d = (wr && off == OFF_RISE_EN) ? NIO'(sel_merge(32'(rise_en_q), wb.wbs_dat_i, wb.wbs_sel_i)) : rise_en_q;
    fall_en_d = (wr && off == OFF_FALL_EN) ? NIO'(sel_merge(32'(fall_en_q), wb.wbs_dat_i, wb.wbs_sel_i)) : fall_en_q;
    clr       = (wr && off == OFF_STATUS)  ? NIO'(wb.wbs_dat_i & byte_mask(wb.wbs_sel_i)) : '0;
    // New edges are OR-ed in after the W1C so a simultaneous set survives the clear
    status_d  = (status_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
    rdata_d   = (accept && !wb.wbs_we_i) ? rd_val : (accept ? '0 : rdata_q);
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      rdata_q   <= '0;
      ovr_out_q <= '0;
      ovr_en_q  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      ovr_out_q <= ovr_out_d;
      ovr_en_q  <= ovr_en_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
    end
  end
  always_comb begin
    state_d = (state_q == S_IDLE) ? (accept ? S_ACK : S_IDLE) : S_IDLE;
  end
  always_comb begin
    wb.wbs_ack_o = (state_q == S_ACK);
    wb.wbs_dat_o = (state_q == S_ACK) ? rdata_q : '0;
    ovr_out      = ovr_out_q;
    ovr_en       = ovr_en_q;
    irq_o        = |(status_q & (rise_en_q | fall_en_q));
  end
endmodule

// File: tb/tb_user_io_wb_ctrl.sv
// tb_user_io_wb_ctrl: scoreboard bench for user_io_wb_ctrl; read data expectations are queued per transaction.
module tb_user_io_wb_ctrl;
  import user_io_pkg::*;
  localparam int S = 2;
  localparam logic [31:0] BASE = 32'h3000_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] io_in = '0;
  logic [31:0] ovr_out, ovr_en;
  logic irq;
  int n_chk = 0;
  int n_fail = 0;
  string sb_tag[$];
  logic [31:0] sb_exp[$];
  user_io_wb_ctrl_if wb();
  user_io_wb_ctrl #(.NIO(32), .BASE_ADDR(BASE), .SYNC_STAGES(S)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wb      (wb),
    .io_in   (io_in),
    .ovr_out (ovr_out),
    .ovr_en  (ovr_en),
    .irq_o   (irq)
  );
  always #5 clk = ~clk;
`ifdef USER_IO_TIMESTAMP_EN
  logic [31:0] ref_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) ref_cnt <= '0;
    else ref_cnt <= ref_cnt + 32'd1;
  end
`endif
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (wb.wbs_ack_o === 1'b1) begin
      if (sb_exp.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
      else check(sb_tag.pop_front(), wb.wbs_dat_o, sb_exp.pop_front());
    end
  end
  task automatic bus(input string tag, input logic we, input logic [7:0] off, input logic [31:0] dat,
                     input logic [3:0] sel, input logic [31:0] exp);
    int n = 0;
    sb_tag.push_back(tag);
    sb_exp.push_back(exp);
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_sel_i = sel;
    wb.wbs_adr_i = BASE + 32'(off);
    wb.wbs_dat_i = dat;
    do begin
      @(negedge clk);
      n++;
    end while (wb.wbs_ack_o !== 1'b1 && n < 10);
    check({tag, "_ack"}, 32'(wb.wbs_ack_o), 32'd1);
    if (wb.wbs_ack_o !== 1'b1) begin
      void'(sb_tag.pop_back());
      void'(sb_exp.pop_back());
    end
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    @(negedge clk);
    check({tag, "_ack_len"}, 32'(wb.wbs_ack_o), 32'd0);
  endtask
  task automatic wr(input string tag, input logic [7:0] off, input logic [31:0] dat, input logic [3:0] sel);
    bus(tag, 1'b1, off, dat, sel, 32'd0);
  endtask
  task automatic rd(input string tag, input logic [7:0] off, input logic [31:0] exp);
    bus(tag, 1'b0, off, 32'd0, 4'hF, exp);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int seen;
`ifdef USER_IO_TIMESTAMP_EN
    logic [31:0] n0;
`endif
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = '0;
    wb.wbs_adr_i = '0;
    wb.wbs_dat_i = '0;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(wb.wbs_ack_o), 32'd0);
    check("rst_dat", wb.wbs_dat_o, 32'd0);
    check("rst_ovr_en", ovr_en, 32'd0);
    check("rst_ovr_out", ovr_out, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    wr("en_b0", OFF_OVR_EN, 32'h0000_00FF, 4'b0001);
    wr("en_b1", OFF_OVR_EN, 32'hFFFF_FFFF, 4'b0010);
    rd("en_rd", OFF_OVR_EN, 32'h0000_FFFF);
    check("ovr_en_pin", ovr_en, 32'h0000_FFFF);
    wr("out_wr", OFF_OVR_OUT, 32'hA5A5_5A5A, 4'hF);
    wr("out_b3", OFF_OVR_OUT, 32'h1234_5678, 4'b1000);
    rd("out_rd", OFF_OVR_OUT, 32'h12A5_5A5A);
    check("ovr_out_pin", ovr_out, 32'h12A5_5A5A);
    io_in = 32'h8000_0000;
    repeat (S + 1) @(negedge clk);
    rd("in_rd", OFF_IN, 32'h8000_0000);
    rd("status_idle", OFF_STATUS, 32'd0);
    wr("rise_en", OFF_RISE_EN, 32'h1, 4'hF);
    io_in[0] = 1'b1;
    repeat (S) @(negedge clk);
    check("irq_early", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_lat", 32'(irq), 32'd1);
    rd("status_rise", OFF_STATUS, 32'h1);
    wr("w1c", OFF_STATUS, 32'h1, 4'hF);
    check("irq_cleared", 32'(irq), 32'd0);
    rd("status_clr", OFF_STATUS, 32'h0);
    io_in[0] = 1'b0;
    repeat (S + 2) @(negedge clk);
    rd("status_nofall", OFF_STATUS, 32'h0);
    io_in[0] = 1'b1;
    repeat (S) @(negedge clk);
    wr("w1c_race", OFF_STATUS, 32'h1, 4'hF);
    rd("status_race", OFF_STATUS, 32'h1);
    check("irq_race", 32'(irq), 32'd1);
    wr("rise_off", OFF_RISE_EN, 32'h0, 4'hF);
    check("irq_masked", 32'(irq), 32'd0);
    rd("status_masked", OFF_STATUS, 32'h1);
    wr("w1c_2", OFF_STATUS, 32'hFFFF_FFFF, 4'hF);
    rd("status_zero", OFF_STATUS, 32'h0);
    rd("id", OFF_ID, IO_ID);
    rd("hole_3c", 8'h3C, 32'd0);
`ifndef USER_IO_TIMESTAMP_EN
    rd("cnt_absent", OFF_CNT, 32'd0);
    rd("tstamp_absent", OFF_TSTAMP, 32'd0);
`endif
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_sel_i = 4'hF;
    wb.wbs_adr_i = BASE + 32'h100;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (wb.wbs_ack_o === 1'b1) seen++;
    end
    check("oow_noack", 32'(seen), 32'd0);
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    @(negedge clk);
`ifdef USER_IO_TIMESTAMP_EN
    io_in[1] = 1'b1;
    repeat (S + 2) @(negedge clk);
    wr("fall_en2", OFF_FALL_EN, 32'h2, 4'hF);
    rd("cnt", OFF_CNT, ref_cnt);
    n0 = ref_cnt;
    io_in[1] = 1'b0;
    repeat (S + 3) @(negedge clk);
    rd("tstamp", OFF_TSTAMP, n0 + 32'(S) + 32'd1);
    io_in[1] = 1'b1;
    repeat (2) @(negedge clk);
    io_in[1] = 1'b0;
    repeat (S + 3) @(negedge clk);
    rd("tstamp_hold", OFF_TSTAMP, n0 + 32'(S) + 32'd1);
    wr("w1c_ts", OFF_STATUS, 32'h2, 4'hF);
`endif
    wr("fall_en0", OFF_FALL_EN, 32'h1, 4'hF);
    io_in[0] = 1'b0;
    repeat (S + 1) @(negedge clk);
    check("irq_fall", 32'(irq), 32'd1);
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_adr_i = BASE + 32'(OFF_ID);
    @(posedge clk);
    #1 check("ack_pre_rst", 32'(wb.wbs_ack_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ack", 32'(wb.wbs_ack_o), 32'd0);
    check("mid_rst_dat", wb.wbs_dat_o, 32'd0);
    check("mid_rst_ovr_en", ovr_en, 32'd0);
    check("mid_rst_irq", 32'(irq), 32'd0);
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ack", 32'(wb.wbs_ack_o), 32'd0);
    rd("retry_id", OFF_ID, IO_ID);
    rd("post_rst_en", OFF_OVR_EN, 32'd0);
    check("sb_empty", 32'(sb_exp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
